key_expand_ctrl: RTL and testbench
==================================

Name: key_expand_ctrl

Overview:
Iterative AES-128 key-schedule controller that sequences one external sub_word unit to produce all 11 round keys (round 0..10) from a 128-bit cipher key. The block issues one round key per accepted transfer over a valid/ready stream to the round-key store or cipher core. It owns the sub_word select input and always requests forward S-box substitution, because the key schedule uses the forward S-box in both encryption and decryption.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds after round 0 (fixed 10 for AES-128; other values unsupported)

Ports:
clk_i  input  1  single clock, rising edge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  begin expansion; sampled only in IDLE
key_i  input  128  cipher key, sampled on the accepted start edge; word w0 = [127:96]
sw_word_o  output  32  word driven to the shared sub_word word_i
sw_enc_or_dec_o  output  1  to sub_word enc_or_dec_i; constant 1
sw_word_i  input  32  sub_word result (combinational return)
rk_valid_o  output  1  round key valid
rk_ready_i  input  1  consumer ready
rk_addr_o  output  4  round index 0..10 of rk_data_o
rk_data_o  output  128  round key
busy_o  output  1  expansion in progress
done_o  output  1  one-cycle pulse after round key 10 is accepted

Behaviour:
- Clock and reset: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, rk_valid_o=0, rk_addr_o=0, rk_data_o=0, busy_o=0, done_o=0, internal key register=0, round counter=0. sw_enc_or_dec_o is 1 at all times, including during reset.
- Datapath: sw_word_o = RotWord(key_reg[31:0]) = {key_reg[23:0], key_reg[31:24]}. It is combinational from key_reg, so the path out through sub_word and back adds no cycle.
- Next-key computation:
  - t = sw_word_i ^ {rcon[r],24'h0}, where r is the index of the key being produced.
  - n0 = k0^t, n1 = k1^n0, n2 = k2^n1, n3 = k3^n2.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- States:
  - IDLE: busy_o=0. When start_i=1, on that edge: key_reg<=key_i, rk_data_o<=key_i, rk_addr_o<=0, rk_valid_o<=1, busy_o<=1, go to EMIT.
  - EMIT: hold rk_valid_o, rk_addr_o and rk_data_o stable while rk_ready_i=0.
    - On a transfer (valid&ready) with rk_addr_o<10: compute the next key from key_reg; load it into key_reg and rk_data_o; rk_addr_o+1; rk_valid_o stays 1.
    - On a transfer with rk_addr_o==10: rk_valid_o<=0, busy_o<=0, done_o<=1, go to DONE.
  - DONE: done_o is high for exactly this one cycle; return to IDLE on the next edge. A start_i in DONE is ignored.
- Throughput: with rk_ready_i held at 1, a start accepted in cycle N gives:
  - rk_valid_o high in cycles N+1..N+11 (addr 0..10);
  - done_o high in cycle N+12;
  - start_i can be accepted again in cycle N+13 at the earliest.
- start_i while busy is ignored; key_i changes while busy have no effect.
- rk_ready_i while rk_valid_o=0 has no effect.
- rst_i mid-operation: takes priority over every other input. Outputs return to reset values on that edge, no further keys are emitted, and no done_o pulse is produced.
- rst_i and start_i in the same cycle: reset wins; start is lost.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready_i=1 -> addr0 = key; addr1 = a0fafe1788542cb123a339392a6c7605; addr10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done_o in cycle N+12.
2. Same key, check sub_word hookup while addr0 is presented -> sw_word_o = cf4f3c09, sw_word_i = 8a84eb01 (real sub_word attached), sw_enc_or_dec_o = 1.
3. Backpressure: rk_ready_i random 50%, plus a 7-cycle stall at addr 4 -> data and addr held stable during stalls; 11 transfers in order 0..10 with the same values as test 1; exactly one done_o pulse.
4. start_i pulsed at addr 3 with a different key_i -> sequence unaffected; the second start is only honoured in IDLE.
5. rst_i asserted at addr 6 -> next cycle rk_valid_o=0, busy_o=0; no done_o. A following start with the all-zero key gives addr1 = 62636363626363636263636362636363.
6. rst_i and start_i high together in IDLE -> block stays in IDLE, busy_o=0.

Source files
------------

// File: rtl/key_expand_ctrl.sv
// AES-128 key-schedule controller. It drives one shared sub_word unit
// (forward S-box only) and emits round keys 0..10 one at a time over a
// valid/ready stream. A transfer happens on a rising edge where rk_valid_o
// and rk_ready_i are both high; while valid is high and ready is low,
// addr and data are held unchanged.
module key_expand_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    output logic [31:0]  sw_word_o,
    output logic         sw_enc_or_dec_o,
    input  logic [31:0]  sw_word_i,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic [3:0]   rk_addr_o,
    output logic [127:0] rk_data_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [127:0] key_reg;
    logic [127:0] next_key;
    logic [3:0]   round;
    logic [3:0]   round_next;
    logic [7:0]   rcon;
    logic [31:0]  t_word;
    logic [31:0]  n0;
    logic [31:0]  n1;
    logic [31:0]  n2;
    logic [31:0]  n3;
    logic         xfer;
    logic         last;
    logic         load_start;
    logic         load_next;
    logic         finish;

    // The key schedule uses the forward S-box for both directions.
    assign sw_enc_or_dec_o = 1'b1;

    // RotWord of the last word goes straight out to sub_word; the result
    // returns combinationally in the same cycle.
    assign sw_word_o = {key_reg[23:0], key_reg[31:24]};

    assign xfer       = rk_valid_o & rk_ready_i;
    assign last       = (round == 4'(NUM_ROUNDS));
    assign round_next = round + 4'd1;
    assign rk_addr_o  = round;

    // Round constant for the key about to be produced (index round+1).
    always_comb begin
        rcon = 8'h00;
        case (round_next)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Next round key from the current key and the sub_word result.
    always_comb begin
        t_word   = sw_word_i ^ {rcon, 24'h000000};
        n0       = key_reg[127:96] ^ t_word;
        n1       = key_reg[95:64]  ^ n0;
        n2       = key_reg[63:32]  ^ n1;
        n3       = key_reg[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only honoured in IDLE, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i)      state_next = EMIT;
            EMIT:    if (xfer && last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state datapath controls.
    always_comb begin
        load_start = 1'b0;
        load_next  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE:    load_start = start_i;
            EMIT: begin
                load_next = xfer & ~last;
                finish    = xfer & last;
            end
            default: ;
        endcase
    end

    // Key register, round counter and registered stream/status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_reg    <= '0;
            rk_data_o  <= '0;
            round      <= '0;
            rk_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= finish;
            if (load_start) begin
                key_reg    <= key_i;
                rk_data_o  <= key_i;
                round      <= '0;
                rk_valid_o <= 1'b1;
                busy_o     <= 1'b1;
            end else if (load_next) begin
                key_reg   <= next_key;
                rk_data_o <= next_key;
                round     <= round_next;
            end else if (finish) begin
                rk_valid_o <= 1'b0;
                busy_o     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Bench for key_expand_ctrl: a real forward S-box serves as the sub_word
// unit, a FIPS-197 style key expansion supplies expected round keys, and a
// negedge monitor checks the stream against an expected queue every cycle.
module tb_key_expand_ctrl;

    logic         clk;
    logic         rst_i;
    logic         start_i;
    logic [127:0] key_i;
    logic [31:0]  sw_word_o;
    logic         sw_enc_or_dec_o;
    logic [31:0]  sw_word_i;
    logic         rk_valid_o;
    logic         rk_ready_i;
    logic [3:0]   rk_addr_o;
    logic [127:0] rk_data_o;
    logic         busy_o;
    logic         done_o;

    key_expand_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .key_i          (key_i),
        .sw_word_o      (sw_word_o),
        .sw_enc_or_dec_o(sw_enc_or_dec_o),
        .sw_word_i      (sw_word_i),
        .rk_valid_o     (rk_valid_o),
        .rk_ready_i     (rk_ready_i),
        .rk_addr_o      (rk_addr_o),
        .rk_data_o      (rk_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- sub_word unit (forward S-box) ----------------
    logic [7:0] sbox [256];
    initial begin
        sbox = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
        };
    end

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_w(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    assign sw_word_i = sub_w(sw_word_o);

    // ---------------- model: textbook 44-word key expansion ----------------
    logic [127:0] model_rk [11];

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = sub_w(rot_w(tmp)) ^ {rc, 24'h0};
                rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    logic [131:0] exp_q [$];
    logic         expect_done = 1'b0;
    logic         mon_en      = 1'b0;
    int           done_cnt    = 0;
    int           done_cyc    = 0;
    int           start_cyc   = 0;
    logic [127:0] got_rk [11];
    logic [31:0]  sw_o_cap;
    logic [31:0]  sw_i_cap;
    logic         sw_enc_cap;

    // Per-cycle compare of the stream, status and sub_word hookup.
    always @(negedge clk) begin
        logic [131:0] head;
        logic         nd;
        if (mon_en) begin
            check("sw_enc_or_dec", 128'(sw_enc_or_dec_o), 128'(1));
            check("done_o", 128'(done_o), 128'(expect_done));
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            check("rk_valid_o", 128'(rk_valid_o), 128'(exp_q.size() != 0));
            check("busy_o", 128'(busy_o), 128'(exp_q.size() != 0));
            nd = 1'b0;
            if (rk_valid_o && exp_q.size() != 0) begin
                head = exp_q[0];
                check("rk_addr_o", 128'(rk_addr_o), 128'(head[131:128]));
                check("rk_data_o", rk_data_o, head[127:0]);
                check("sw_word_o", 128'(sw_word_o), 128'(rot_w(head[31:0])));
                if (head[131:128] == 4'd0) begin
                    sw_o_cap   = sw_word_o;
                    sw_i_cap   = sw_word_i;
                    sw_enc_cap = sw_enc_or_dec_o;
                end
                if (rk_ready_i) begin
                    got_rk[head[131:128]] = rk_data_o;
                    nd = (head[131:128] == 4'd10);
                    void'(exp_q.pop_front());
                end
            end
            expect_done = nd;
        end
    end

    // ---------------- ready driver ----------------
    int ready_mode = 0;  // 0: always ready, 1: random with 7-cycle stall at addr 4
    int stall_cnt  = 0;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            rk_ready_i = 1'b1;
        end else if (rk_valid_o && rk_addr_o == 4'd4 && stall_cnt < 7) begin
            rk_ready_i = 1'b0;
            stall_cnt++;
        end else begin
            rk_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic start_key(input logic [127:0] k);
        key_i     = k;
        start_i   = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        key_i   = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        for (int r = 0; r < 11; r++) exp_q.push_back({4'(r), model_rk[r]});
    endtask

    task automatic wait_done(input int limit);
        int base;
        bit seen;
        base = done_cnt;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk);
            if (done_cnt != base) seen = 1;
        end
        #1;
        check("done_timeout", 128'(seen), 128'(1));
    endtask

    task automatic wait_addr(input logic [3:0] a, input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk);
            #1;
            if (rk_valid_o && rk_addr_o == a) seen = 1;
        end
        check("addr_timeout", 128'(seen), 128'(1));
    endtask

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;

    // ---------------- main sequence ----------------
    initial begin
        int base;
        rst_i      = 1'b1;
        start_i    = 1'b0;
        key_i      = '0;
        rk_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rk_valid_o", 128'(rk_valid_o), 128'(0));
        check("reset rk_addr_o", 128'(rk_addr_o), 128'(0));
        check("reset rk_data_o", rk_data_o, 128'(0));
        check("reset busy_o", 128'(busy_o), 128'(0));
        check("reset done_o", 128'(done_o), 128'(0));
        check("reset sw_word_o", 128'(sw_word_o), 128'(0));
        check("reset sw_enc", 128'(sw_enc_or_dec_o), 128'(1));
        @(posedge clk);
        #1;
        rst_i  = 1'b0;
        mon_en = 1'b1;

        // Model pinned against published vectors.
        expand(FIPS_KEY);
        check("model fips rk1", model_rk[1], FIPS_RK1);
        check("model fips rk10", model_rk[10], FIPS_RK10);
        expand('0);
        check("model zero rk1", model_rk[1], ZERO_RK1);

        // 1/2: FIPS key, ready always high.
        ready_mode = 0;
        @(posedge clk); #1;
        start_key(FIPS_KEY);
        wait_done(40);
        check("t1 rk0", got_rk[0], FIPS_KEY);
        check("t1 rk1", got_rk[1], FIPS_RK1);
        check("t1 rk10", got_rk[10], FIPS_RK10);
        check("t1 done latency", 128'(done_cyc - start_cyc), 128'(12));
        check("t2 sw_word_o", 128'(sw_o_cap), 128'(32'hcf4f3c09));
        check("t2 sw_word_i", 128'(sw_i_cap), 128'(32'h8a84eb01));
        check("t2 sw_enc", 128'(sw_enc_cap), 128'(1));

        // 3: random backpressure with a long stall at addr 4.
        ready_mode = 1;
        stall_cnt  = 0;
        got_rk     = '{default: '0};
        base       = done_cnt;
        start_key(FIPS_KEY);
        wait_done(400);
        repeat (3) @(posedge clk);
        #1;
        check("t3 stall length", 128'(stall_cnt), 128'(7));
        check("t3 rk1", got_rk[1], FIPS_RK1);
        check("t3 rk10", got_rk[10], FIPS_RK10);
        check("t3 done count", 128'(done_cnt - base), 128'(1));

        // 4: start pulsed mid-run and in DONE is ignored.
        ready_mode = 0;
        @(posedge clk); #1;
        base = done_cnt;
        start_key(FIPS_KEY);
        wait_addr(4'd3, 20);
        start_i = 1'b1;
        key_i   = 128'h000102030405060708090a0b0c0d0e0f;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_addr(4'd10, 20);
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t4 done count", 128'(done_cnt - base), 128'(1));
        check("t4 idle busy_o", 128'(busy_o), 128'(0));
        check("t4 rk10", got_rk[10], FIPS_RK10);

        // 5: reset at addr 6, then an all-zero key.
        base = done_cnt;
        start_key(FIPS_KEY);
        wait_addr(4'd6, 20);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        exp_q.delete();
        check("t5 rk_valid_o after reset", 128'(rk_valid_o), 128'(0));
        check("t5 busy_o after reset", 128'(busy_o), 128'(0));
        repeat (15) @(posedge clk);
        #1;
        check("t5 no done", 128'(done_cnt - base), 128'(0));
        start_key('0);
        wait_done(40);
        check("t5 zero rk1", got_rk[1], ZERO_RK1);

        // 6: reset and start together in IDLE.
        @(posedge clk); #1;
        rst_i   = 1'b1;
        start_i = 1'b1;
        key_i   = FIPS_KEY;
        @(posedge clk); #1;
        rst_i   = 1'b0;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6 busy_o", 128'(busy_o), 128'(0));
        check("t6 rk_valid_o", 128'(rk_valid_o), 128'(0));
        check("t6 queue empty", 128'(exp_q.size()), 128'(0));

        @(negedge clk);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
